ultrasonic_ranger: RTL and testbench



---
 rtl/ultrasonic_ranger.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// ---------------------------------------------------------------------------
// ultrasonic_ranger
//
// Controls an HC-SR04-style ultrasonic sensor and turns the echo pulse width
// into whole centimetres. It runs continuously: hold off, trigger, wait for
// the echo rise, measure, report, and then repeat.
//
// Centimetres are counted as the pulse arrives. A sub-counter divides the echo
// high-time into CLK_PER_CM-cycle slices, and each completed slice adds one to
// the cm count. No divider is needed.
//
// Optional build macro:
//   RANGER_ROUND_EN - when defined, the sub-counter is preloaded with
//                     CLK_PER_CM/2 on entry to S_MEASURE. The result then
//                     rounds to the nearest cm instead of truncating.
//                     Flags and timing do not change.
//
// Parameters:
//   CLK_PER_CM        clock cycles of echo high-time per cm
//   TRIG_CYC          trigger pulse length in cycles
//   RISE_TIMEOUT_CYC  max cycles to wait for echo rise after trigger ends
//   MAX_CM            saturation value of the cm count
//   HOLDOFF_CYC       cycles echo must be continuously low before a trigger
//
// Ports:
//   clock         system clock
//   reset         synchronous, active-high reset
//   echo          sensor echo pin (asynchronous, synchronised here)
//   trigger       sensor trigger pin, registered
//   distance      last measured distance in cm, zero-extended to 32 bits
//   done          one-cycle pulse when a measurement completes
//   no_echo       last measurement timed out waiting for the echo rise
//   out_of_range  last measurement saturated at MAX_CM
// ---------------------------------------------------------------------------
module ultrasonic_ranger #(
    parameter int CLK_PER_CM       = 2900,
    parameter int TRIG_CYC         = 500,
    parameter int RISE_TIMEOUT_CYC = 1_500_000,
    parameter int MAX_CM           = 400,
    parameter int HOLDOFF_CYC      = 3_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        echo,
    output logic        trigger,
    output logic [31:0] distance,
    output logic        done,
    output logic        no_echo,
    output logic        out_of_range
);

    // -----------------------------------------------------------------------
    // Widths and constants
    // -----------------------------------------------------------------------
    localparam int SYNC_STAGES = 2;

    // A single phase counter serves holdoff, trigger length and rise
    // timeout. It is sized for the largest of the three.
    localparam int CNT_LIMIT_A = (HOLDOFF_CYC > TRIG_CYC) ? HOLDOFF_CYC : TRIG_CYC;
    localparam int CNT_LIMIT   = (CNT_LIMIT_A > RISE_TIMEOUT_CYC) ? CNT_LIMIT_A
                                                                  : RISE_TIMEOUT_CYC;
    localparam int CNT_W = $clog2(CNT_LIMIT) + 1;
    localparam int SUB_W = $clog2(CLK_PER_CM) + 1;
    localparam int CM_W  = $clog2(MAX_CM) + 1;

`ifdef RANGER_ROUND_EN
    localparam int SUB_PRELOAD = CLK_PER_CM / 2;
`else
    localparam int SUB_PRELOAD = 0;
`endif

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] RISE_LAST  = CNT_W'(RISE_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CLK_PER_CM - 1);
    localparam logic [SUB_W-1:0] SUB_INIT   = SUB_W'(SUB_PRELOAD);
    localparam logic [SUB_W-1:0] SUB_ONE    = SUB_W'(1);
    localparam logic [CM_W-1:0]  CM_MAX     = CM_W'(MAX_CM);
    localparam logic [CM_W-1:0]  CM_ONE     = CM_W'(1);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_HOLDOFF   = 2'd0,
        S_TRIG      = 2'd1,
        S_WAIT_RISE = 2'd2,
        S_MEASURE   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   echo_s;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SUB_W-1:0] sub_reg, sub_next;
    logic [CM_W-1:0]  cm_reg,  cm_next;

    logic             trigger_reg, trigger_next;
    logic             done_reg, done_next;
    logic             no_echo_reg, no_echo_next;
    logic             oor_reg, oor_next;
    logic [CM_W-1:0]  distance_reg, distance_next;

    // One echo-high slice step, shared by the rise cycle and S_MEASURE.
    logic [SUB_W-1:0] step_base_sub;
    logic [CM_W-1:0]  step_base_cm;
    logic [SUB_W-1:0] step_sub;
    logic [CM_W-1:0]  step_cm;

    // -----------------------------------------------------------------------
    // Echo synchroniser. echo is asynchronous to clock, so everything
    // downstream looks only at echo_s.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], echo};
        end
    end

    assign echo_s = sync_reg[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Slice step.
    //
    // The rise cycle counts as echo cycle 1. On that cycle the step starts
    // from the preload with a zero cm count. In S_MEASURE it continues from
    // the running counters. The sub-counter wraps as it leaves CLK_PER_CM-1.
    // That makes W high cycles produce floor((W + preload) / CLK_PER_CM) cm.
    // -----------------------------------------------------------------------
    always_comb begin
        step_base_sub = SUB_INIT;
        step_base_cm  = '0;
        if (state_reg == S_MEASURE) begin
            step_base_sub = sub_reg;
            step_base_cm  = cm_reg;
        end

        step_sub = step_base_sub + SUB_ONE;
        step_cm  = step_base_cm;
        if (step_base_sub == SUB_LAST) begin
            step_sub = '0;
            if (step_base_cm != CM_MAX) begin
                step_cm = step_base_cm + CM_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register and all output/result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_HOLDOFF;
            cnt_reg      <= '0;
            sub_reg      <= '0;
            cm_reg       <= '0;
            trigger_reg  <= 1'b0;
            done_reg     <= 1'b0;
            no_echo_reg  <= 1'b0;
            oor_reg      <= 1'b0;
            distance_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            sub_reg      <= sub_next;
            cm_reg       <= cm_next;
            trigger_reg  <= trigger_next;
            done_reg     <= done_next;
            no_echo_reg  <= no_echo_next;
            oor_reg      <= oor_next;
            distance_reg <= distance_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and result logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        sub_next      = sub_reg;
        cm_next       = cm_reg;
        done_next     = 1'b0;
        no_echo_next  = no_echo_reg;
        oor_next      = oor_reg;
        distance_next = distance_reg;

        unique case (state_reg)
            S_HOLDOFF: begin
                // The echo must stay low for a full HOLDOFF_CYC run. Any high
                // cycle restarts the count, so a stuck-high echo blocks the
                // next trigger indefinitely.
                if (echo_s) begin
                    cnt_next = '0;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = S_TRIG;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_TRIG: begin
                // The echo is deliberately ignored while triggering.
                if (cnt_reg == TRIG_LAST) begin
                    state_next = S_WAIT_RISE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_WAIT_RISE: begin
                if (echo_s) begin
                    state_next = S_MEASURE;
                    cnt_next   = '0;
                    sub_next   = step_sub;
                    cm_next    = step_cm;
                end else if (cnt_reg == RISE_LAST) begin
                    // Timed out: report no-echo and keep the old distance.
                    state_next   = S_HOLDOFF;
                    cnt_next     = '0;
                    done_next    = 1'b1;
                    no_echo_next = 1'b1;
                    oor_next     = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_MEASURE: begin
                if (echo_s) begin
                    sub_next = step_sub;
                    cm_next  = step_cm;
                end else begin
                    // The first low cycle ends the pulse. It is not counted.
                    state_next    = S_HOLDOFF;
                    cnt_next      = '0;
                    done_next     = 1'b1;
                    no_echo_next  = 1'b0;
                    oor_next      = (cm_reg == CM_MAX);
                    distance_next = cm_reg;
                end
            end

            default: begin
                state_next = S_HOLDOFF;
                cnt_next   = '0;
            end
        endcase
    end

    // The trigger is registered from the next state. It rises on the same
    // edge that enters S_TRIG and falls on the edge that leaves it.
    assign trigger_next = (state_next == S_TRIG);

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign trigger      = trigger_reg;
    assign done         = done_reg;
    assign no_echo      = no_echo_reg;
    assign out_of_range = oor_reg;
    assign distance     = {{(32 - CM_W){1'b0}}, distance_reg};

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// ---------------------------------------------------------------------------
// tb_ultrasonic_ranger
//
// Directed and randomized bench for ultrasonic_ranger, using small
// parameters. Expected values come from the sensor rules:
//   * distance = min(floor((W + bias) / CLK_PER_CM), MAX_CM), where bias is
//     CLK_PER_CM/2 when RANGER_ROUND_EN is defined and 0 otherwise
//   * done arrives 3 clocks after the echo pin falls
//   * the rise timeout is RISE_TIMEOUT_CYC cycles after the trigger falls
//   * the next trigger comes HOLDOFF_CYC cycles after done, or
//     HOLDOFF_CYC + 2 cycles after a late echo fall
// ---------------------------------------------------------------------------
module tb_ultrasonic_ranger;

    localparam int CPC  = 4;
    localparam int TRIG = 5;
    localparam int RISE = 50;
    localparam int MAXC = 20;
    localparam int HOLD = 10;
    localparam int SYNC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        echo;
    logic        trigger;
    logic [31:0] distance;
    logic        done;
    logic        no_echo;
    logic        out_of_range;

    int checks = 0;
    int errors = 0;
    int exp_dist = 0;   // reference: last reported distance

    always #5 clock = ~clock;

    ultrasonic_ranger #(
        .CLK_PER_CM       (CPC),
        .TRIG_CYC         (TRIG),
        .RISE_TIMEOUT_CYC (RISE),
        .MAX_CM           (MAXC),
        .HOLDOFF_CYC      (HOLD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .echo         (echo),
        .trigger      (trigger),
        .distance     (distance),
        .done         (done),
        .no_echo      (no_echo),
        .out_of_range (out_of_range)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    function automatic int model_cm(input int w);
        int r;
`ifdef RANGER_ROUND_EN
        r = (w + CPC / 2) / CPC;
`else
        r = w / CPC;
`endif
        return (r > MAXC) ? MAXC : r;
    endfunction

    // Waits for the trigger to rise and checks the gap and the pulse width.
    // It also checks that done stays low throughout, which confirms that any
    // earlier done was a single-cycle pulse. It returns once trigger is low.
    task automatic wait_trigger(input string tag, input int exp_gap);
        int gap = 0;
        int hi  = 0;
        int dn  = 0;
        while (trigger !== 1'b1 && gap < 500) begin
            tick();
            gap++;
            if (done === 1'b1) dn++;
        end
        check(tag, "trig_gap", gap, exp_gap);
        while (trigger === 1'b1 && hi < 100) begin
            tick();
            hi++;
            if (done === 1'b1) dn++;
        end
        check(tag, "trig_width", hi, TRIG);
        check(tag, "done_quiet", dn, 0);
        $display("trigger %s gap=%0d width=%0d", tag, gap, hi);
    endtask

    // Called just after the trigger falls. It idles d cycles and drives the
    // echo high for w cycles, then expects done exactly 3 clocks after the
    // fall, with the modelled distance and flags.
    task automatic measure(input string tag, input int d, input int w);
        int dn = 0;
        int e;
        repeat (d) begin
            tick();
            if (done === 1'b1) dn++;
        end
        echo = 1'b1;
        repeat (w) begin
            tick();
            if (done === 1'b1) dn++;
        end
        echo = 1'b0;
        repeat (SYNC) begin
            tick();
            if (done === 1'b1) dn++;
        end
        check(tag, "no_early_done", dn, 0);
        tick();
        check(tag, "done", {31'd0, done}, 1);
        e = model_cm(w);
        exp_dist = e;
        check(tag, "distance", distance, e);
        check(tag, "no_echo", {31'd0, no_echo}, 0);
        check(tag, "out_of_range", {31'd0, out_of_range}, (e == MAXC) ? 1 : 0);
        $display("measure %s delay=%0d width=%0d distance=%0d expected=%0d oor=%0d",
                 tag, d, w, distance, e, out_of_range);
    endtask

    // Called just after the trigger falls. With no echo, done must come
    // RISE cycles later, flagged no_echo, with the old distance kept.
    task automatic timeout(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(tag, "timeout_cycles", n, RISE);
        check(tag, "no_echo", {31'd0, no_echo}, 1);
        check(tag, "out_of_range", {31'd0, out_of_range}, 0);
        check(tag, "distance_hold", distance, exp_dist);
        $display("timeout %s cycles=%0d distance=%0d", tag, n, distance);
    endtask

    // Watchdog: guards against anything that escapes the local bounds.
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int trig_seen;
        int dn_seen;
        int w;
        int d;

        // ---------------- reset state ----------------
        reset = 1'b1;
        echo  = 1'b0;
        repeat (3) tick();
        check("reset", "trigger", {31'd0, trigger}, 0);
        check("reset", "distance", distance, 0);
        check("reset", "done", {31'd0, done}, 0);
        check("reset", "no_echo", {31'd0, no_echo}, 0);
        check("reset", "out_of_range", {31'd0, out_of_range}, 0);
        $display("reset distance=%0d trigger=%0d", distance, trigger);
        reset = 1'b0;

        // ---------------- first trigger after reset release ----------------
        wait_trigger("por", HOLD);

        // ---------------- directed widths ----------------
        measure("w40", 7, 40);
        wait_trigger("after_w40", HOLD);
        measure("w43", 3, 43);
        wait_trigger("after_w43", HOLD);
        measure("w41", 0, 41);
        wait_trigger("after_w41", HOLD);

        // ---------------- no echo ----------------
        timeout("noecho");
        wait_trigger("after_noecho", HOLD);

        // ---------------- saturation and stuck-high echo in holdoff ----------------
        measure("w100", 5, 100);
        echo = 1'b1;
        trig_seen = 0;
        repeat (30) begin
            tick();
            if (trigger === 1'b1) trig_seen++;
        end
        check("stuck", "no_trigger", trig_seen, 0);
        echo = 1'b0;
        wait_trigger("stuck_release", HOLD + SYNC);

        // ---------------- randomized measurements ----------------
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                timeout("rnd_noecho");
            end else begin
                w = int'($urandom_range(1, 110));
                d = int'($urandom_range(0, 30));
                measure("rnd", d, w);
            end
            wait_trigger("rnd_next", HOLD);
        end

        // ---------------- reset in the middle of an echo pulse ----------------
        repeat (3) tick();
        echo = 1'b1;
        dn_seen = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) dn_seen++;
        end
        reset = 1'b1;
        repeat (2) tick();
        check("midreset", "trigger", {31'd0, trigger}, 0);
        check("midreset", "distance", distance, 0);
        check("midreset", "done", {31'd0, done}, 0);
        check("midreset", "no_echo", {31'd0, no_echo}, 0);
        check("midreset", "out_of_range", {31'd0, out_of_range}, 0);
        exp_dist = 0;
        reset = 1'b0;
        trig_seen = 0;
        repeat (15) begin
            tick();
            if (trigger === 1'b1) trig_seen++;
            if (done === 1'b1) dn_seen++;
        end
        check("midreset", "no_trigger", trig_seen, 0);
        check("midreset", "no_done", dn_seen, 0);
        $display("midreset distance=%0d done_seen=%0d trig_seen=%0d",
                 distance, dn_seen, trig_seen);
        echo = 1'b0;
        wait_trigger("midreset_release", HOLD + SYNC);

        // ---------------- recovery after reset ----------------
        measure("recover", 2, 57);
        wait_trigger("after_recover", HOLD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
